// File: rtl/sw_pkg.sv
// Switch packet format shared by the switch and its output receive buffers.
// Packet: [PKTW] valid, [PKTW-1 -: DSTW] one-hot destination, remainder payload.
package sw_pkg;

   localparam int unsigned PKTW    = 12;
   localparam int unsigned PORT    = 3;
   localparam int unsigned DSTW    = PORT + 1;
   localparam int unsigned DST_MSB = PKTW - 1;
   localparam int unsigned DST_LSB = PKTW - DSTW;
   localparam int unsigned PAY_W   = DST_LSB;

   typedef logic [PKTW:0] pkt_t;

   function automatic logic [DSTW-1:0] dest_onehot(input int unsigned port);
      return DSTW'(1) << port;
   endfunction

endpackage

// File: rtl/ob_rx_if.sv
// Packet handshake between a switch output, its receive buffer and the local sink.
// slave: the buffer (ob_rx); master: the surrounding switch/sink environment.
interface ob_rx_if;
   import sw_pkg::*;

   pkt_t pi;
   pkt_t po;
   logic po_valid;
   logic po_ready;

   modport master (output pi, output po_ready, input po, input po_valid);
   modport slave (input pi, input po_ready, output po, output po_valid);

endinterface

// File: rtl/ob_fifo.sv
// First-word fall-through FIFO of DEPTH packets; head is 0 while empty.
// Occupancy kept in a separate count one bit wider than the pointers.
module ob_fifo
   import sw_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wr_en_i,
   input  pkt_t wdata_i,
   input  logic rd_en_i,
   output pkt_t rdata_o,
   output logic valid_o,
   output logic full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   pkt_t          mem_q [DEPTH];
   pkt_t          mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en_i) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en_i) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_en_i, rd_en_i})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign valid_o = (cnt_q != '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ob_rx.sv
// Receive buffer for one switch output: drops on full (counted), delivers via valid/ready.
// Define OB_MISROUTE_CHK_EN to count packets whose destination is not this port.
module ob_rx
   import sw_pkg::*;
#(
   parameter int unsigned PORT_ID = 0,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNTW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   ob_rx_if.slave          bus,
   output logic            full,
   output logic [CNTW-1:0] drop_cnt,
   output logic [CNTW-1:0] mis_cnt
);

   logic pi_valid;
   logic deq;
   logic enq;
   logic drop;

   logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

   assign pi_valid = bus.pi[PKTW];
   assign deq      = bus.po_valid & bus.po_ready;
   // The switch cannot stall, so a full buffer only accepts when the sink frees a slot.
   assign enq      = pi_valid & (~full | deq);
   assign drop     = pi_valid & full & ~deq;

   ob_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_en_i (enq),
      .wdata_i (bus.pi),
      .rd_en_i (deq),
      .rdata_o (bus.po),
      .valid_o (bus.po_valid),
      .full_o  (full)
   );

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;

`ifdef OB_MISROUTE_CHK_EN
   logic            misrouted;
   logic [CNTW-1:0] mis_cnt_q, mis_cnt_d;

   assign misrouted = pi_valid & (bus.pi[DST_MSB:DST_LSB] != dest_onehot(PORT_ID));

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      if (misrouted && (mis_cnt_q != '1)) begin
         mis_cnt_d = mis_cnt_q + CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_cnt_q <= '0;
      end else begin
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign mis_cnt = mis_cnt_q;
`else
   assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_ob_rx.sv
// Self-checking bench for ob_rx: directed scenarios plus random traffic against a queue model.
// Misroute expectations follow OB_MISROUTE_CHK_EN as compiled.
module tb_ob_rx;
   import sw_pkg::*;

   localparam int unsigned PORT_ID = 2;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned CNTW    = 2;
   localparam int          SAT     = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            full;
   logic [CNTW-1:0] drop_cnt;
   logic [CNTW-1:0] mis_cnt;

   ob_rx_if bus ();

   ob_rx #(
      .PORT_ID (PORT_ID),
      .DEPTH   (DEPTH),
      .CNTW    (CNTW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .full     (full),
      .drop_cnt (drop_cnt),
      .mis_cnt  (mis_cnt)
   );

   always #5 clk = ~clk;

   pkt_t mq[$];
   int   m_drop;
   int   m_mis;
   int   n_cmp;
   int   n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      pkt_t head;
      head = (mq.size() != 0) ? mq[0] : '0;
      check_eq("po_valid", 32'(bus.po_valid), 32'(mq.size() != 0));
      check_eq("po", 32'(bus.po), 32'(head));
      check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
      check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check_eq("mis_cnt", 32'(mis_cnt), 32'(m_mis));
   endtask

   function automatic pkt_t mk(input logic [DSTW-1:0] dst, input logic [PAY_W-1:0] pay);
      return {1'b1, dst, pay};
   endfunction

   // Called at a falling edge: check, drive this cycle's inputs, advance the model one edge.
   task automatic cycle(input pkt_t p, input logic rdy);
      logic            deq;
      logic            was_full;
      logic [DSTW-1:0] own;
      check_all();
      bus.pi       = p;
      bus.po_ready = rdy;
      own      = DSTW'(1) << PORT_ID;
      deq      = (mq.size() != 0) && rdy;
      was_full = (mq.size() == DEPTH);
      if (p[PKTW]) begin
`ifdef OB_MISROUTE_CHK_EN
         if (p[DST_MSB:DST_LSB] != own && m_mis < SAT) m_mis++;
`endif
         if (was_full && !deq && m_drop < SAT) m_drop++;
      end
      if (deq) void'(mq.pop_front());
      if (p[PKTW] && (!was_full || deq)) mq.push_back(p);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      bus.pi       = '0;
      bus.po_ready = 1'b0;
      #1;
      check_eq("rst_po_valid", 32'(bus.po_valid), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_drop", 32'(drop_cnt), 32'd0);
      check_eq("rst_mis", 32'(mis_cnt), 32'd0);
      mq.delete();
      m_drop = 0;
      m_mis  = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [DSTW-1:0] own;
      pkt_t            p;
      own    = DSTW'(1) << PORT_ID;
      n_cmp  = 0;
      n_err  = 0;
      m_drop = 0;
      m_mis  = 0;
      rst          = 1'b1;
      bus.pi       = '0;
      bus.po_ready = 1'b0;
      #1 check_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // One packet, sink ready: visible the next cycle, then gone.
      cycle(mk(own, 8'h5A), 1'b1);
      cycle('0, 1'b1);
      cycle('0, 1'b1);

      // Five back-to-back with sink stalled: fifth dropped; then drain in order.
      for (int i = 0; i < 5; i++) cycle(mk(own, PAY_W'(8'h10 + i)), 1'b0);
      for (int i = 0; i < 5; i++) cycle('0, 1'b1);

      // Full with simultaneous dequeue and arrival: no drop.
      for (int i = 0; i < 4; i++) cycle(mk(own, PAY_W'(8'h20 + i)), 1'b0);
      cycle(mk(own, 8'h2F), 1'b1);
      for (int i = 0; i < 5; i++) cycle('0, 1'b1);

      // Misrouted destination is still delivered.
      cycle(mk(4'b0001, 8'h77), 1'b0);
      cycle('0, 1'b0);
      cycle('0, 1'b1);

      // Async reset with three entries queued; a new packet emerges first.
      for (int i = 0; i < 3; i++) cycle(mk(own, PAY_W'(8'h30 + i)), 1'b0);
      async_reset();
      cycle(mk(own, 8'hC3), 1'b0);
      cycle('0, 1'b1);

      // Drop counter saturation with the FIFO held full.
      for (int i = 0; i < 4; i++) cycle(mk(own, PAY_W'(8'h40 + i)), 1'b0);
      for (int i = 0; i < 4; i++) cycle(mk(own, PAY_W'(8'h50 + i)), 1'b0);
      async_reset();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [DSTW-1:0] dst;
         if ($urandom_range(0, 3) == 0) dst = DSTW'($urandom_range(0, 15));
         else dst = DSTW'(1) << $urandom_range(0, 3);
         p = mk(dst, PAY_W'($urandom_range(0, 255)));
         if ($urandom_range(0, 9) < 3) p = '0;
         cycle(p, 1'($urandom_range(0, 1)));
         if (i == 200) async_reset();
      end
      check_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
